// File: rtl/coin_acceptor_pkg.sv
// Shared coin codes, coin values in cents and accept/dispense state encoding.
// Pure definitions: no latency, no flow control.
package coin_pkg;

    localparam int CREDIT_W_DEF = 9;
    localparam int COIN_VAL_W   = 5;

    typedef enum logic [1:0] {
        COIN_PENNY   = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_type_e;

    localparam logic [COIN_VAL_W-1:0] VAL_PENNY   = 5'd1;
    localparam logic [COIN_VAL_W-1:0] VAL_NICKEL  = 5'd5;
    localparam logic [COIN_VAL_W-1:0] VAL_DIME    = 5'd10;
    localparam logic [COIN_VAL_W-1:0] VAL_QUARTER = 5'd25;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_CREDIT   = 2'b01,
        ST_DISPENSE = 2'b10
    } state_e;

endpackage

// File: rtl/coin_acceptor_if.sv
// Coin-slot, select/cancel requests and the registered vend/change results.
// Pulse signalling only: no ready/backpressure in either direction.
interface coin_acceptor_if #(
    parameter int CREDIT_W = 9
);
    logic                coin_valid;
    logic [1:0]          coin_type;
    logic [CREDIT_W-1:0] price;
    logic                select;
    logic                cancel;
    logic [CREDIT_W-1:0] credit;
    logic                coin_accept;
    logic                coin_reject;
    logic                vend;
    logic                short_funds;
    logic [CREDIT_W-1:0] change;
    logic                change_valid;

    modport master (
        output coin_valid, coin_type, price, select, cancel,
        input  credit, coin_accept, coin_reject, vend, short_funds, change, change_valid
    );

    modport slave (
        input  coin_valid, coin_type, price, select, cancel,
        output credit, coin_accept, coin_reject, vend, short_funds, change, change_valid
    );
endinterface

// File: rtl/coin_value_lut.sv
// Maps a 2-bit coin code to its value in cents.
// Combinational, zero latency; no flow control.
module coin_value_lut
    import coin_pkg::*;
(
    input  logic [1:0]            coin_type_i,
    output logic [COIN_VAL_W-1:0] value_o
);

    always_comb begin
        value_o = VAL_PENNY;
        case (coin_type_e'(coin_type_i))
            COIN_PENNY:   value_o = VAL_PENNY;
            COIN_NICKEL:  value_o = VAL_NICKEL;
            COIN_DIME:    value_o = VAL_DIME;
            COIN_QUARTER: value_o = VAL_QUARTER;
            default:      value_o = VAL_PENNY;
        endcase
    end

endmodule

// File: rtl/coin_acceptor.sv
// Accumulates coin credit, services select/cancel and emits vend + change.
// Coin result 1 cycle, dispense 2 cycles; never stalls, refused coins are rejected.
module coin_acceptor
    import coin_pkg::*;
#(
    parameter int CREDIT_W   = CREDIT_W_DEF,
    parameter int MAX_CREDIT = 500
) (
    input  logic           clk,
    input  logic           rst_n,
    coin_acceptor_if.slave bus
);

    localparam logic [CREDIT_W:0] MAX_CREDIT_EXT = (CREDIT_W+1)'(MAX_CREDIT);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] pend_change_q, pend_change_d;
    logic                pend_vend_q, pend_vend_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                coin_accept_q, coin_accept_d;
    logic                coin_reject_q, coin_reject_d;
    logic                vend_q, vend_d;
    logic                short_funds_q, short_funds_d;
    logic                change_valid_q, change_valid_d;

    logic [COIN_VAL_W-1:0] coin_val;
    logic [CREDIT_W:0]     credit_sum;

    coin_value_lut u_value_lut (
        .coin_type_i (bus.coin_type),
        .value_o     (coin_val)
    );

    // One extra bit so the MAX_CREDIT comparison never sees a wrapped sum.
    assign credit_sum = {1'b0, credit_q} + {{(CREDIT_W+1-COIN_VAL_W){1'b0}}, coin_val};

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        pend_change_d  = pend_change_q;
        pend_vend_d    = pend_vend_q;
        change_d       = change_q;
        coin_accept_d  = 1'b0;
        coin_reject_d  = 1'b0;
        vend_d         = 1'b0;
        short_funds_d  = 1'b0;
        change_valid_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_CREDIT: begin
                if (bus.cancel && (credit_q != '0)) begin
                    pend_change_d = credit_q;
                    pend_vend_d   = 1'b0;
                    credit_d      = '0;
                    coin_reject_d = bus.coin_valid;
                    state_d       = ST_DISPENSE;
                end else if (bus.select) begin
                    // A select owns the cycle even when refused, so a coin with it bounces.
                    coin_reject_d = bus.coin_valid;
                    if (credit_q >= bus.price) begin
                        pend_change_d = credit_q - bus.price;
                        pend_vend_d   = 1'b1;
                        credit_d      = '0;
                        state_d       = ST_DISPENSE;
                    end else begin
                        short_funds_d = 1'b1;
                    end
                end else if (bus.coin_valid) begin
                    if (credit_sum <= MAX_CREDIT_EXT) begin
                        credit_d      = credit_sum[CREDIT_W-1:0];
                        coin_accept_d = 1'b1;
                        state_d       = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_DISPENSE: begin
                change_d       = pend_change_q;
                change_valid_d = 1'b1;
                vend_d         = pend_vend_q;
                coin_reject_d  = bus.coin_valid;
                state_d        = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            pend_change_q  <= '0;
            pend_vend_q    <= 1'b0;
            change_q       <= '0;
            coin_accept_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_q         <= 1'b0;
            short_funds_q  <= 1'b0;
            change_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            pend_change_q  <= pend_change_d;
            pend_vend_q    <= pend_vend_d;
            change_q       <= change_d;
            coin_accept_q  <= coin_accept_d;
            coin_reject_q  <= coin_reject_d;
            vend_q         <= vend_d;
            short_funds_q  <= short_funds_d;
            change_valid_q <= change_valid_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.coin_accept  = coin_accept_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.vend         = vend_q;
    assign bus.short_funds  = short_funds_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;

endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Upstream front end of the vending datapath. It accepts one coin per cycle from the coin-slot sensor and accumulates credit in cents. On a product select it compares credit against the product price and issues a vend together with the change amount. On cancel it refunds the whole credit. The `change` output is the 9-bit cents value consumed by `dispenseChange`, which converts it to quarter/dime/nickel/penny counts.

## Interface
Parameters:
- `CREDIT_W`, 9: credit, price and change width in cents; must match the `dispenseChange` `change` input.
- `MAX_CREDIT`, 500: highest credit accepted; a coin that would exceed it is rejected.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `coin_valid` input 1: one coin present this cycle.
- `coin_type` input 2: coin code; 00 = penny (1), 01 = nickel (5), 10 = dime (10), 11 = quarter (25).
- `price` input CREDIT_W: price of the selected product; sampled only in the cycle `select` is high.
- `select` input 1: purchase request, single-cycle pulse.
- `cancel` input 1: refund request, single-cycle pulse.
- `credit` output CREDIT_W: current accumulated credit.
- `coin_accept` output 1: pulse, coin added.
- `coin_reject` output 1: pulse, coin returned to the user, credit unchanged.
- `vend` output 1: pulse, dispense product.
- `short_funds` output 1: pulse, select refused because credit < price.
- `change` output CREDIT_W: change amount; held until the next dispense.
- `change_valid` output 1: pulse, `change` is newly valid for `dispenseChange`.

## Operation
- FSM states:
  - IDLE: credit = 0.
  - CREDIT: credit > 0.
  - DISPENSE: one cycle, after an accepted select or cancel.
- Request priority per cycle, evaluated in IDLE/CREDIT: `cancel` > `select` > `coin_valid`.
- Coin in IDLE/CREDIT, no cancel/select:
  - If `credit + value <= MAX_CREDIT`: credit += value, `coin_accept`, go to CREDIT.
  - Otherwise: `coin_reject`, credit held.
- Select with `credit >= price`: `change <= credit - price`, credit cleared to 0, go to DISPENSE.
- Select with `credit < price`: `short_funds`, credit held, no state change.
- Select with `price = 0` is accepted; it vends and change equals the full credit.
- Cancel with credit > 0: `change <= credit`, credit cleared to 0, go to DISPENSE with no vend.
- Cancel in IDLE (credit = 0): no outputs asserted, state stays IDLE.
- A coin arriving in the same cycle as a serviced cancel or select is rejected (`coin_reject`).
- DISPENSE:
  - Assert `change_valid`.
  - Assert `vend` only if entered by select.
  - Any `coin_valid` in this cycle is rejected; `select` and `cancel` are ignored.
  - Next state is IDLE.
- Arithmetic: the sum is computed at CREDIT_W+1 bits before comparison with MAX_CREDIT, so there is no wrap-around. The subtraction is unsigned and guarded by the `>=` check.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, state IDLE.
- Coin to `credit` update and `coin_accept`/`coin_reject`: 1 cycle.
- Select/cancel to `change` valid and `change_valid`/`vend`: 2 cycles (request → DISPENSE state → registered pulse).
- `vend` and `change_valid` are coincident single-cycle pulses.
- Minimum spacing between dispenses: 2 cycles. Back-to-back coins are accepted every cycle outside DISPENSE.
- Reset mid-operation: credit is lost and pulses are aborted immediately (asynchronous). No refund is issued.

## Structure
- Package `coin_pkg`:
  - Coin-type codes: `COIN_PENNY`, `COIN_NICKEL`, `COIN_DIME`, `COIN_QUARTER`.
  - Coin values in cents: 1, 5, 10, 25.
  - Default `CREDIT_W`.
  - State encoding: IDLE, CREDIT, DISPENSE.
- Sub-module `coin_value_lut`: combinational mapping from `coin_type` to value in cents. The same values are reused by the `dispenseChange` checks.

## Test plan
- Reset, then insert Q, Q, D, D (one per cycle) → `credit` = 25, 50, 60, 70; four `coin_accept` pulses. Then price = 63, select → 2 cycles later `vend` = 1, `change` = 7, `change_valid` = 1, `credit` = 0. Downstream `dispenseChange` shows 0 quarters, 0 dimes, 1 nickel, 2 pennies.
- Credit 30, price 37, select → `short_funds` pulse, `credit` stays 30, no `vend`.
- Credit 37, cancel → `change` = 37, `change_valid` = 1, `vend` = 0. Downstream `dispenseChange` shows 1 quarter, 1 dime, 0 nickels, 2 pennies.
- Credit 490, insert quarter → `coin_reject`, `credit` stays 490. Then insert dime → `credit` = 500.
- Credit 25 with cancel, select (price 10) and a coin all in the same cycle → refund `change` = 25, no `vend`, coin rejected.
- Credit 40, select at price 40, then `rst_n` pulsed low during the DISPENSE cycle → all outputs immediately 0, no `change_valid`, FSM in IDLE.
